// File: rtl/channel_sched.sv
// Time-multiplexed channel scheduler: per-channel sample FIFOs drained one slot
// per cycle onto a registered stream, zero-filling empty slots and flagging underruns.
module channel_sched #(
    parameter int NCH   = 4,
    parameter int DW    = 7,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        num_ch,
    input  logic              clr_flags,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic [DW-1:0]     data,
    output logic [1:0]        ch_sel,
    output logic              out_valid,
    output logic              frame_start,
    output logic [NCH-1:0]    underrun,
    output logic [7:0]        underrun_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [1:0]      num_ch_q, num_ch_d;
    logic [CW-1:0]   count_q [NCH];
    logic [CW-1:0]   count_d [NCH];
    logic [DW-1:0]   mem_q [NCH][DEPTH];
    logic [DW-1:0]   mem_d [NCH][DEPTH];
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      ch_sel_q, ch_sel_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_start_q, frame_start_d;
    logic [NCH-1:0]  underrun_q, underrun_d;
    logic [7:0]      underrun_cnt_q, underrun_cnt_d;

    logic            issue;
    logic            last;
    logic [1:0]      eff_num;

    // Slot 0 latches num_ch, so the frame it opens already uses the new value.
    assign issue   = (state_q != IDLE);
    assign eff_num = (slot_q == 2'd0) ? num_ch : num_ch_q;
    assign last    = issue && (slot_q == eff_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            num_ch_q       <= '0;
            count_q        <= '{default: '0};
            mem_q          <= '{default: '0};
            data_q         <= '0;
            ch_sel_q       <= '0;
            out_valid_q    <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= '0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            num_ch_q       <= num_ch_d;
            count_q        <= count_d;
            mem_q          <= mem_d;
            data_q         <= data_d;
            ch_sel_q       <= ch_sel_d;
            out_valid_q    <= out_valid_d;
            frame_start_q  <= frame_start_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        num_ch_d = num_ch_q;
        case (state_q)
            IDLE: begin
                slot_d = '0;
                if (en) begin
                    state_d  = RUN;
                    num_ch_d = num_ch;
                end
            end
            RUN: begin
                if (!en) state_d = last ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (en)        state_d = RUN;
                else if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            slot_d = last ? 2'd0 : slot_q + 2'd1;
            if (slot_q == 2'd0) num_ch_d = num_ch;
        end
    end

    always_comb begin
        logic          push;
        logic          pop;
        logic [CW-1:0] wr_idx;
        in_ready = '0;
        count_d  = count_q;
        mem_d    = mem_q;
        for (int unsigned k = 0; k < NCH; k++) begin
            in_ready[k] = (count_q[k] < DEPTH_C);
            push   = in_valid[k] && in_ready[k];
            pop    = issue && (slot_q == 2'(k)) && (count_q[k] != '0);
            wr_idx = count_q[k] - CW'(pop);
            // Shift-register FIFO: head always at entry 0, pop shifts before push lands.
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_d[k][i] = mem_q[k][i+1];
            end
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) mem_d[k][i] = in_data[k*DW +: DW];
                end
            end
            count_d[k] = count_q[k] + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        data_d         = '0;
        ch_sel_d       = '0;
        out_valid_d    = 1'b0;
        frame_start_d  = 1'b0;
        underrun_d     = underrun_q;
        underrun_cnt_d = underrun_cnt_q;
        if (clr_flags) begin
            underrun_d     = '0;
            underrun_cnt_d = '0;
        end
        if (issue) begin
            out_valid_d   = 1'b1;
            ch_sel_d      = slot_q;
            frame_start_d = (slot_q == 2'd0);
            if (count_q[slot_q] != '0) begin
                data_d = mem_q[slot_q][0];
            end else begin
                underrun_d[slot_q] = 1'b1;
                if (underrun_cnt_d != '1) underrun_cnt_d = underrun_cnt_d + 8'd1;
            end
        end
    end

    assign data         = data_q;
    assign ch_sel       = ch_sel_q;
    assign out_valid    = out_valid_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_channel_sched.sv
// Directed bench for channel_sched: fixed stimulus sequences with hand-derived
// expected stream, flag and ready values.
module tb_channel_sched;

    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    num_ch;
    logic          clr_flags;
    logic [3:0]    in_valid;
    logic [27:0]   in_data;
    logic [3:0]    in_ready;
    logic [DW-1:0] data;
    logic [1:0]    ch_sel;
    logic          out_valid;
    logic          frame_start;
    logic [3:0]    underrun;
    logic [7:0]    underrun_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] neg30;

    always #5 clk = ~clk;

    channel_sched #(.NCH(4), .DW(DW), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .num_ch       (num_ch),
        .clr_flags    (clr_flags),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .data         (data),
        .ch_sel       (ch_sel),
        .out_valid    (out_valid),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] c,
                              input logic [DW-1:0] d, input logic fs);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_ch"},    32'(ch_sel),    32'(c));
        check({tag, "_data"},  32'(data),      32'(d));
        check({tag, "_fs"},    32'(frame_start), 32'(fs));
    endtask

    task automatic offer(input int ch, input logic [DW-1:0] val);
        in_data[ch*DW +: DW] = val;
        in_valid[ch]         = 1'b1;
    endtask

    initial begin
        neg30     = -7'sd30;
        rst_n     = 1'b0;
        en        = 1'b0;
        num_ch    = 2'd0;
        clr_flags = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        tick; tick;
        expect_out("rst", 1'b0, 2'd0, '0, 1'b0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_cnt", 32'(underrun_cnt), 32'h0);
        check("rst_ready", 32'(in_ready), 32'hF);
        rst_n = 1'b1;
        tick;

        // two full frames on channels 0..1
        num_ch = 2'd1;
        offer(0, 7'd60); offer(1, 7'd50); tick; in_valid = '0;
        offer(0, 7'd55); offer(1, 7'd40); tick; in_valid = '0;
        check("a_ready", 32'(in_ready), 32'hC);
        en = 1'b1; tick;
        expect_out("a_start", 1'b0, 2'd0, '0, 1'b0);
        tick; expect_out("a0", 1'b1, 2'd0, 7'd60, 1'b1);
        tick; expect_out("a1", 1'b1, 2'd1, 7'd50, 1'b0);
        tick; expect_out("a2", 1'b1, 2'd0, 7'd55, 1'b1);
        en = 1'b0;
        tick; expect_out("a3", 1'b1, 2'd1, 7'd40, 1'b0);
        tick; expect_out("a_idle", 1'b0, 2'd0, '0, 1'b0);
        check("a_underrun", 32'(underrun), 32'h0);
        check("a_ready_after", 32'(in_ready), 32'hF);

        // channel 1 empty: zero fill and underrun
        offer(0, neg30); tick; in_valid = '0;
        en = 1'b1; tick; en = 1'b0;
        tick; expect_out("b0", 1'b1, 2'd0, neg30, 1'b1);
        tick; expect_out("b1", 1'b1, 2'd1, '0, 1'b0);
        check("b_underrun", 32'(underrun), 32'h2);
        check("b_cnt", 32'(underrun_cnt), 32'd1);
        tick; expect_out("b_idle", 1'b0, 2'd0, '0, 1'b0);
        check("b_sticky", 32'(underrun), 32'h2);
        clr_flags = 1'b1; tick; clr_flags = 1'b0;
        check("clr_underrun", 32'(underrun), 32'h0);
        check("clr_cnt", 32'(underrun_cnt), 32'd0);

        // unscheduled channel 2 fills and drops the third sample
        offer(2, 7'd11); tick; in_valid = '0;
        check("c_ready1", 32'(in_ready), 32'hF);
        offer(2, 7'd22); tick; in_valid = '0;
        check("c_ready2", 32'(in_ready), 32'hB);
        offer(2, 7'd33); tick; in_valid = '0;
        check("c_ready3", 32'(in_ready), 32'hB);

        // en dropped while slot 1 issues: frame still completes
        num_ch = 2'd3;
        offer(0, 7'd1); offer(1, 7'd2); offer(3, 7'd4); tick; in_valid = '0;
        check("d_ready", 32'(in_ready), 32'hB);
        en = 1'b1; tick;
        tick; expect_out("d0", 1'b1, 2'd0, 7'd1, 1'b1);
        en = 1'b0;
        tick; expect_out("d1", 1'b1, 2'd1, 7'd2, 1'b0);
        tick; expect_out("d2", 1'b1, 2'd2, 7'd11, 1'b0);
        tick; expect_out("d3", 1'b1, 2'd3, 7'd4, 1'b0);
        tick; expect_out("d_idle", 1'b0, 2'd0, '0, 1'b0);
        check("d_ready_after", 32'(in_ready), 32'hF);
        check("d_underrun", 32'(underrun), 32'h0);

        // num_ch 1->3 mid-frame; clr_flags coincides with a new underrun
        offer(0, 7'd5); offer(1, 7'd7); offer(3, 7'd9); tick; in_valid = '0;
        offer(0, 7'd6); tick; in_valid = '0;
        num_ch = 2'd1; en = 1'b1; tick;
        tick; expect_out("e0", 1'b1, 2'd0, 7'd5, 1'b1);
        num_ch = 2'd3;
        tick; expect_out("e1", 1'b1, 2'd1, 7'd7, 1'b0);
        tick; expect_out("e2", 1'b1, 2'd0, 7'd6, 1'b1);
        clr_flags = 1'b1;
        tick; clr_flags = 1'b0;
        expect_out("e3", 1'b1, 2'd1, '0, 1'b0);
        check("e_underrun", 32'(underrun), 32'h2);
        check("e_cnt", 32'(underrun_cnt), 32'd1);
        tick; expect_out("e4", 1'b1, 2'd2, 7'd22, 1'b0);
        en = 1'b0;
        tick; expect_out("e5", 1'b1, 2'd3, 7'd9, 1'b0);
        tick; expect_out("e_idle", 1'b0, 2'd0, '0, 1'b0);

        // asynchronous reset mid-frame discards buffered samples
        offer(0, 7'd3); offer(1, 7'd4); tick; in_valid = '0;
        num_ch = 2'd1; en = 1'b1; tick;
        tick; expect_out("f0", 1'b1, 2'd0, 7'd3, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_out("f_rst", 1'b0, 2'd0, '0, 1'b0);
        check("f_rst_underrun", 32'(underrun), 32'h0);
        check("f_rst_cnt", 32'(underrun_cnt), 32'd0);
        check("f_rst_ready", 32'(in_ready), 32'hF);
        tick;
        rst_n = 1'b1;
        tick; check("f_restart_idle", 32'(out_valid), 32'd0);
        tick; expect_out("f_first", 1'b1, 2'd0, '0, 1'b1);
        check("f_underrun", 32'(underrun), 32'h1);
        en = 1'b0;
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/channel_sched.md
CHANNEL_SCHED -- requirements
Module: channel_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of physical channels (fixed at 4; ch_sel width 2).
REQ-002 SHALL have parameter DW, default 7, meaning sample width (signed two's complement).
REQ-003 SHALL have parameter DEPTH, default 2, meaning per-channel buffer entries.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port en  input  1  run request for the time-multiplexed stream.
REQ-007 SHALL have port num_ch  input  2  highest active channel index (0..3).
REQ-008 SHALL have port clr_flags  input  1  single-cycle clear of underrun flags and counter.
REQ-009 SHALL have port in_valid  input  4  per-channel sample offered.
REQ-010 SHALL have port in_data  input  28  packed samples, channel k in bits [7k+6:7k].
REQ-011 SHALL have port in_ready  output  4  per-channel buffer can accept.
REQ-012 SHALL have port data  output  7  sample to downstream sorting datapath.
REQ-013 SHALL have port ch_sel  output  2  channel tag of data.
REQ-014 SHALL have port out_valid  output  1  data/ch_sel carry a scheduled slot.
REQ-015 SHALL have port frame_start  output  1  pulse with slot for channel 0.
REQ-016 SHALL have port underrun  output  4  sticky per-channel underrun flags.
REQ-017 SHALL have port underrun_cnt  output  8  saturating total underrun count.

Function
REQ-018 SHALL hold a DEPTH-entry FIFO per channel; in_ready[k] = (count[k] < DEPTH), from registered count only.
REQ-019 SHALL push in_data slice k when in_valid[k] && in_ready[k]; valid without ready is ignored, no flag.
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-021 SHALL in IDLE hold slot=0 and drive out_valid=0, data=0, ch_sel=0; move to RUN when en=1.
REQ-022 SHALL latch num_ch into num_ch_q on IDLE->RUN and at every slot-0 issue; num_ch changes mid-frame take effect next frame.
REQ-023 SHALL in RUN/DRAIN issue exactly one slot per cycle: slot counter 0,1,..,num_ch_q, then wraps to 0.
REQ-024 SHALL register outputs: slot s issued in cycle t appears on data/ch_sel/out_valid=1 in cycle t+1 (latency 1).
REQ-025 SHALL on issuing slot s with count[s]>0 pop the head entry onto data.
REQ-026 SHALL on issuing slot s with count[s]=0 drive data=0 with out_valid=1 (zero fill keeps TDM alignment), set underrun[s], and increment underrun_cnt saturating at 255.
REQ-027 SHALL assert frame_start for the output cycle carrying ch_sel=0.
REQ-028 SHALL allow simultaneous push and pop on one channel in one cycle; count unchanged, FIFO order preserved, no underrun when count was 0 is not applicable (pop precedes push: empty buffer still underruns).
REQ-029 SHALL move RUN->DRAIN when en=0; DRAIN continues slots until slot num_ch_q is issued, then IDLE (frame always completed).
REQ-030 SHALL return DRAIN->RUN if en reasserts before the last slot is issued.
REQ-031 SHALL clear underrun and underrun_cnt on clr_flags; a same-cycle new underrun wins (flag set, count=1).
REQ-032 SHALL never issue a slot index greater than num_ch_q; channels above num_ch_q keep buffering until full.

Reset
REQ-033 SHALL on rst_n=0 immediately clear FSM to IDLE, slot=0, all FIFO counts/pointers, data=0, ch_sel=0, out_valid=0, frame_start=0, underrun=0, underrun_cnt=0; in_ready=4'b1111 thereafter.
REQ-034 SHALL discard buffered samples on reset mid-frame; first post-reset slot is channel 0.

Verification
REQ-035 SHALL verify: num_ch=1, push ch0 60,55 and ch1 50,40, en=1 -> outputs (ch,data) = (0,60),(1,50),(0,55),(1,40), frame_start on ch0 cycles.
REQ-036 SHALL verify: num_ch=1, ch1 empty, ch0 holds -30 -> (0,-30),(1,0) with underrun=4'b0010, underrun_cnt=1.
REQ-037 SHALL verify: ch2 pushed 3 times while not scheduled -> in_ready[2]=0 after 2 pushes, third sample dropped, FIFO holds first two.
REQ-038 SHALL verify: num_ch=3, en dropped while slot 1 issued -> slots 2,3 still output, then out_valid=0 and IDLE.
REQ-039 SHALL verify: num_ch changed 1->3 mid-frame -> current frame ends at ch1, next frame runs ch0..ch3.
REQ-040 SHALL verify: rst_n pulsed low mid-frame -> all outputs 0 within same cycle, in_ready=4'b1111, restart emits ch0 first.
